pio_mem_rd_arb_512: RTL and testbench
=====================================

# pio_mem_rd_arb_512

Arbiter sharing the single 512-bit read port (port B) of the PIO memory between two read requesters: requester 0 is the TX completion engine, requester 1 is the local debug/scrub reader. Round-robin grant with credit-based response buffering per requester. Optional same-word read/write hazard stall against the RX write port. Sits between the requesters and the 1-cycle-latency PIO memory.

## Interface
- BYTE_ADDR_WIDTH, 13, byte address width (8 KB space)
- DATA_WIDTH, 512, memory word width
- WORD_LSB, 6, first word-address bit; bits [WORD_LSB-1:0] are byte offset
- RSP_DEPTH, 2, response FIFO entries per requester (power of 2, >=2)

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- r0_req_valid / r1_req_valid  in  1  read request
- r0_req_ready / r1_req_ready  out  1  request accepted this cycle
- r0_req_addr / r1_req_addr  in  BYTE_ADDR_WIDTH  byte address
- r0_rsp_valid / r1_rsp_valid  out  1  response word available
- r0_rsp_ready / r1_rsp_ready  in  1  requester pops response
- r0_rsp_data / r1_rsp_data  out  DATA_WIDTH  full memory word
- mem_rd_en  out  1  memory read enable
- mem_rd_addr  out  BYTE_ADDR_WIDTH  byte address to memory
- mem_rd_data  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_rd_en
- mem_wr_en  in  1  monitored RX write enable
- mem_wr_addr  in  BYTE_ADDR_WIDTH  monitored RX write byte address

## Operation
- Eligibility of requester i: ri_req_valid && credit_i > 0 && !hazard_i.
- credit_i = RSP_DEPTH − fifo_count_i − inflight_i; inflight_i is 1 when granted in the previous cycle.
- Round-robin: state last_grant (1 bit). Both eligible → grant !last_grant; one eligible → grant it. last_grant updates only on a grant. Reset value 1 (requester 0 wins first tie).
- At most one grant per cycle. ri_req_ready = grant_i (combinational; may depend on ri_req_valid). Requesters hold valid/addr stable until ready.
- Grant cycle: mem_rd_en=1, mem_rd_addr = granted address (combinational mux); otherwise mem_rd_en=0, mem_rd_addr=0.
- Tag register records granted requester; next cycle mem_rd_data is pushed into that requester's FIFO.
- Response FIFO: ri_rsp_valid = count_i != 0; ri_rsp_data = head entry; pop on valid&&ready. Push and pop in same cycle allowed; count unchanged. Credit scheme guarantees no overflow; overflow is unreachable.
- Pointers wrap modulo RSP_DEPTH; count is $clog2(RSP_DEPTH)+1 bits.
- Hazard (see Configuration): hazard_i = mem_wr_en && ri_req_addr[BYTE_ADDR_WIDTH-1:WORD_LSB] == mem_wr_addr[BYTE_ADDR_WIDTH-1:WORD_LSB].

## Timing
- Request accepted at edge N → mem_rd_data sampled at edge N+1 → ri_rsp_valid high from cycle N+1 onward (after edge N+1). Accept-to-response: 2 edges.
- Back-to-back: one requester with continuous valid and rsp_ready=1 sustains one grant per cycle.
- rsp_ready held low: requester receives exactly RSP_DEPTH grants, then ready stays 0 until a pop; first pop restores one credit the next cycle.
- Reset (asserted any time, including mid-transfer): FIFOs emptied, in-flight tag discarded, last_grant=1. Outputs during reset: all req_ready=0, rsp_valid=0, rsp_data=0, mem_rd_en=0, mem_rd_addr=0. Memory returns after reset are ignored.

## Configuration
- PIO_RD_ARB_HAZARD_STALL_EN defined: hazard_i as above; requester with same-word write in the same cycle is ineligible that cycle (other requester may be granted); read retried automatically next cycle, returning post-write data.
- Not defined: hazard_i tied 0; same-cycle same-word read returns memory-defined (old or new) data, no stall.

## Test plan
- Single read: r0 reads 0x0040, memory word 1 = 0xA5..A5 → r0_rsp_valid after 2 edges, data 0xA5..A5, mem_rd_addr=0x0040.
- Tie: both valid continuously, rsp_ready=1 → grants alternate r0,r1,r0,r1; first grant r0 after reset.
- Backpressure: r1 continuous valid, r1_rsp_ready=0 → exactly 2 grants then r1_req_ready=0; pop once → one more grant next cycle; r0 unaffected.
- Hazard (macro defined): r0 reads 0x0080 while write to 0x00BC with mem_wr_en=1 → no grant that cycle, grant next cycle, response = newly written word; undefined macro → granted same cycle.
- Reset mid-op: assert rst the cycle after a grant → no rsp_valid after deassert, all FIFOs empty, next tie granted to r0.

Source files
------------

// File: rtl/pio_mem_rd_arb_512.sv
// rtl/pio_mem_rd_arb_512.sv - round-robin, credit-based arbiter for the 512-bit PIO memory read port
// Optional same-word read/write hazard stall: define PIO_RD_ARB_HAZARD_STALL_EN.
module pio_mem_rd_arb_512 #(
  parameter int BYTE_ADDR_WIDTH = 13,
  parameter int DATA_WIDTH      = 512,
  parameter int WORD_LSB        = 6,
  parameter int RSP_DEPTH       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       r0_req_valid,
  output logic                       r0_req_ready,
  input  logic [BYTE_ADDR_WIDTH-1:0] r0_req_addr,
  output logic                       r0_rsp_valid,
  input  logic                       r0_rsp_ready,
  output logic [DATA_WIDTH-1:0]      r0_rsp_data,
  input  logic                       r1_req_valid,
  output logic                       r1_req_ready,
  input  logic [BYTE_ADDR_WIDTH-1:0] r1_req_addr,
  output logic                       r1_rsp_valid,
  input  logic                       r1_rsp_ready,
  output logic [DATA_WIDTH-1:0]      r1_rsp_data,
  output logic                       mem_rd_en,
  output logic [BYTE_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]      mem_rd_data,
  input  logic                       mem_wr_en,
  input  logic [BYTE_ADDR_WIDTH-1:0] mem_wr_addr
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_U = (CW+1)'(RSP_DEPTH);

  logic [1:0]                 req_valid, rsp_ready, hazard, eligible, grant, inflight, push, pop;
  logic [BYTE_ADDR_WIDTH-1:0] req_addr [2];
  logic                       last_grant, tag_valid, tag;
  logic [CW-1:0]              count [2];
  logic [PW-1:0]              wr_ptr [2];
  logic [PW-1:0]              rd_ptr [2];
  logic [DATA_WIDTH-1:0]      fifo_mem [2][RSP_DEPTH];

  assign req_valid   = {r1_req_valid, r0_req_valid};
  assign rsp_ready   = {r1_rsp_ready, r0_rsp_ready};
  assign req_addr[0] = r0_req_addr;
  assign req_addr[1] = r1_req_addr;

`ifdef PIO_RD_ARB_HAZARD_STALL_EN
  always_comb begin
    hazard = 2'b00;
    for (int i = 0; i < 2; i++)
      hazard[i] = mem_wr_en &&
                  (req_addr[i][BYTE_ADDR_WIDTH-1:WORD_LSB] == mem_wr_addr[BYTE_ADDR_WIDTH-1:WORD_LSB]);
  end
`else
  logic unused_wr;
  assign unused_wr = ^{mem_wr_en, mem_wr_addr};
  assign hazard    = 2'b00;
`endif

  // A requester is eligible only while its held-plus-in-flight responses leave FIFO room.
  always_comb begin
    inflight = 2'b00;
    eligible = 2'b00;
    push     = 2'b00;
    pop      = 2'b00;
    for (int i = 0; i < 2; i++) begin
      inflight[i] = tag_valid && (tag == 1'(i));
      push[i]     = inflight[i];
      pop[i]      = (count[i] != '0) && rsp_ready[i];
      eligible[i] = req_valid[i] && !hazard[i] &&
                    (({1'b0, count[i]} + {{CW{1'b0}}, inflight[i]}) < DEPTH_U);
    end
  end

  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (&eligible) grant = last_grant ? 2'b01 : 2'b10;
      else           grant = eligible;
    end
  end

  assign r0_req_ready = grant[0];
  assign r1_req_ready = grant[1];
  assign mem_rd_en    = |grant;
  assign mem_rd_addr  = grant[1] ? req_addr[1] : (grant[0] ? req_addr[0] : '0);

  assign r0_rsp_valid = (count[0] != '0);
  assign r1_rsp_valid = (count[1] != '0);
  assign r0_rsp_data  = r0_rsp_valid ? fifo_mem[0][rd_ptr[0]] : '0;
  assign r1_rsp_data  = r1_rsp_valid ? fifo_mem[1][rd_ptr[1]] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      tag_valid  <= 1'b0;
      tag        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      if (|grant) last_grant <= grant[1];
      tag_valid <= |grant;
      tag       <= grant[1];
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
        else if (pop[i] && !push[i]) count[i] <= count[i] - CW'(1);
      end
    end
  end

  // Payload storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push[i]) fifo_mem[i][wr_ptr[i]] <= mem_rd_data;
  end

endmodule

// File: tb/tb_pio_mem_rd_arb_512.sv
// tb/tb_pio_mem_rd_arb_512.sv - directed and randomized checks for pio_mem_rd_arb_512
module tb_pio_mem_rd_arb_512;
  localparam int AW = 13;
  localparam int DW = 512;
  localparam int DEPTH = 2;
  typedef logic [DW-1:0] word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid, rsp_ready;
  logic [AW-1:0] req_addr [2];
  wire  [1:0]    req_ready, rsp_valid;
  wire  [DW-1:0] rsp_data [2];
  wire           mem_rd_en;
  wire  [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  word_t         wr_data;
  word_t         mem [128];

  int passes = 0;
  int fails = 0;
  int total = 0;

  word_t      vq [2][$];
  logic [1:0] pend_v, hold, elig, eg;
  word_t      pend_d [2];
  int         outst [2];
  logic       mlast;

  always #5 clk = ~clk;

  pio_mem_rd_arb_512 dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(req_valid[0]), .r0_req_ready(req_ready[0]), .r0_req_addr(req_addr[0]),
    .r0_rsp_valid(rsp_valid[0]), .r0_rsp_ready(rsp_ready[0]), .r0_rsp_data(rsp_data[0]),
    .r1_req_valid(req_valid[1]), .r1_req_ready(req_ready[1]), .r1_req_addr(req_addr[1]),
    .r1_rsp_valid(rsp_valid[1]), .r1_rsp_ready(rsp_ready[1]), .r1_rsp_data(rsp_data[1]),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr)
  );

  // 1-cycle-latency memory; a same-edge read sees the old word.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[AW-1:6]];
    if (mem_wr_en) mem[mem_wr_addr[AW-1:6]] = wr_data;
  end

  function automatic word_t rand_word();
    word_t v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_addr[0] = '0; req_addr[1] = '0;
    mem_wr_en = 1'b0; mem_wr_addr = '0; wr_data = '0;
    for (int k = 0; k < 128; k++) mem[k] = rand_word();

    // outputs held quiet while in reset, even with requests pending
    req_valid = 2'b11; req_addr[0] = 13'h0040; req_addr[1] = 13'h0080; rsp_ready = 2'b11;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_data0", rsp_data[0], '0);
    chk("rst_rsp_data1", rsp_data[1], '0);
    chk("rst_rd_en", mem_rd_en, 1'b0);
    chk("rst_rd_addr", mem_rd_addr, '0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 2'b00;

    // single read of word 1
    mem[1] = {64{8'hA5}};
    req_addr[0] = 13'h0040; req_valid = 2'b01; rsp_ready = 2'b00;
    @(negedge clk);
    chk("sr_ready", req_ready, 2'b01);
    chk("sr_rd_en", mem_rd_en, 1'b1);
    chk("sr_rd_addr", mem_rd_addr, 13'h0040);
    tick(); req_valid = 2'b00;
    @(negedge clk);
    chk("sr_not_yet", rsp_valid, 2'b00);
    tick();
    @(negedge clk);
    chk("sr_rsp_valid", rsp_valid, 2'b01);
    chk("sr_rsp_data", rsp_data[0], {64{8'hA5}});
    rsp_ready = 2'b11;
    tick();
    @(negedge clk);
    chk("sr_popped", rsp_valid, 2'b00);

    // tie alternates starting with r0
    do_reset();
    req_addr[0] = 13'h00C0; req_addr[1] = 13'h0100; req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("tie_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    req_valid = 2'b00;
    repeat (4) tick();

    // r1 backpressure: two credits, refill one per pop, r0 independent
    rsp_ready = 2'b01; req_addr[1] = 13'h0200; req_valid = 2'b10;
    @(negedge clk); chk("bp_grant1", req_ready, 2'b10); tick();
    @(negedge clk); chk("bp_grant2", req_ready, 2'b10); tick();
    req_valid = 2'b11; req_addr[0] = 13'h0240;
    @(negedge clk); chk("bp_r0_ok", req_ready, 2'b01); tick();
    req_valid = 2'b10;
    @(negedge clk); chk("bp_stall", req_ready, 2'b00);
    chk("bp_r1_rsp", rsp_valid[1], 1'b1); tick();
    rsp_ready = 2'b11;
    @(negedge clk); chk("bp_pop_cycle", req_ready, 2'b00); tick();
    rsp_ready = 2'b01;
    @(negedge clk); chk("bp_regrant", req_ready, 2'b10); tick();
    @(negedge clk); chk("bp_full_again", req_ready, 2'b00);
    req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (5) tick();

    // same-word write while r0 reads 0x0080
    wr_data = rand_word(); mem_wr_addr = 13'h00BC; mem_wr_en = 1'b1;
    req_addr[0] = 13'h0080; req_valid = 2'b01; rsp_ready = 2'b00;
`ifdef PIO_RD_ARB_HAZARD_STALL_EN
    @(negedge clk);
    chk("hz_stall", req_ready, 2'b00);
    chk("hz_rd_en", mem_rd_en, 1'b0);
    tick(); mem_wr_en = 1'b0;
    @(negedge clk); chk("hz_retry", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    tick();
    @(negedge clk);
    chk("hz_rsp_valid", rsp_valid, 2'b01);
    chk("hz_new_data", rsp_data[0], wr_data);
`else
    @(negedge clk);
    chk("hz_no_stall", req_ready, 2'b01);
    chk("hz_rd_addr", mem_rd_addr, 13'h0080);
    tick(); mem_wr_en = 1'b0; req_valid = 2'b00;
    tick();
    @(negedge clk);
    chk("hz_rsp_valid", rsp_valid, 2'b01);
`endif
    rsp_ready = 2'b11;
    repeat (3) tick();

    // reset the cycle after a grant
    req_addr[0] = 13'h0100; req_addr[1] = 13'h0140; req_valid = 2'b01;
    @(negedge clk); chk("rm_grant", req_ready, 2'b01);
    tick();
    rst = 1'b1; req_valid = 2'b11;
    @(negedge clk);
    chk("rm_in_rst_ready", req_ready, 2'b00);
    chk("rm_in_rst_rsp", rsp_valid, 2'b00);
    chk("rm_in_rst_rd_en", mem_rd_en, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rm_after_rsp", rsp_valid, 2'b00);
    chk("rm_tie_r0", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    repeat (4) tick();

    // randomized traffic against a transaction-level model
    do_reset();
    mlast = 1'b1; pend_v = 2'b00; hold = 2'b00;
    for (int i = 0; i < 2; i++) begin outst[i] = 0; vq[i].delete(); end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_addr[i]  = AW'($urandom_range(0, 8191));
        end
      end
      rsp_ready = 2'($urandom);
      for (int i = 0; i < 2; i++) elig[i] = req_valid[i] && (outst[i] < DEPTH);
      eg = (elig == 2'b11) ? (mlast ? 2'b01 : 2'b10) : elig;
      @(negedge clk);
      chk("rnd_req_ready", req_ready, eg);
      chk("rnd_rd_en", mem_rd_en, |eg);
      chk("rnd_rd_addr", mem_rd_addr, eg[1] ? req_addr[1] : (eg[0] ? req_addr[0] : '0));
      for (int i = 0; i < 2; i++) begin
        chk("rnd_rsp_valid", rsp_valid[i], vq[i].size() != 0);
        if (vq[i].size() != 0) chk("rnd_rsp_data", rsp_data[i], vq[i][0]);
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (vq[i].size() != 0 && rsp_ready[i]) begin
          void'(vq[i].pop_front());
          outst[i]--;
        end
        if (pend_v[i]) vq[i].push_back(pend_d[i]);
        pend_v[i] = eg[i];
        if (eg[i]) begin
          pend_d[i] = mem[req_addr[i][AW-1:6]];
          outst[i]++;
        end
        hold[i] = req_valid[i] && !eg[i];
      end
      if (|eg) mlast = eg[1];
      #1;
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
